// File: rtl/core_pkg.sv
// Shared types and widths for the core's cache-miss path.
package core_pkg;

  localparam int unsigned MISS_INFO_W = 149;
  localparam int unsigned LINE_W      = 128;
  localparam int unsigned LINE_ADDR_W = 20;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BEATS       = 4;
  localparam int unsigned BEAT_W      = 2;
  localparam int unsigned TMO_W       = 8;

  localparam logic CACHE_ID_DCACHE = 1'b1;
  localparam logic CACHE_ID_ICACHE = 1'b0;

  // Layout of req_info: [148:129] line addr, [128] write, [127:0] write line
  typedef struct packed {
    logic [LINE_ADDR_W-1:0] line_addr;
    logic                   write;
    logic [LINE_W-1:0]      data;
  } miss_req_t;

endpackage

// File: rtl/miss_req_arbiter.sv
// Holds one pending miss per cache and picks which one the bus master serves next.
module miss_req_arbiter
  import core_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   i_d_valid,
  input  logic [MISS_INFO_W-1:0] i_d_info,
  input  logic                   i_i_valid,
  input  logic [MISS_INFO_W-1:0] i_i_info,
  input  logic                   i_grant_en,
  input  logic                   i_clr,
  input  logic                   i_clr_id,
  output logic                   o_grant_c,
  output logic                   o_grant_id_c,
  output miss_req_t              o_grant_req_c
);

  logic      r_d_flag;
  logic      r_i_flag;
  logic      r_last;
  miss_req_t r_d_req;
  miss_req_t r_i_req;

  logic      w_d_pend;
  logic      w_i_pend;
  logic      w_pick_d;
  miss_req_t w_d_cur;
  miss_req_t w_i_cur;

  // A request arriving this cycle is visible to the grant immediately
  assign w_d_pend = r_d_flag | i_d_valid;
  assign w_i_pend = r_i_flag | i_i_valid;
  assign w_d_cur  = r_d_flag ? r_d_req : miss_req_t'(i_d_info);
  assign w_i_cur  = r_i_flag ? r_i_req : miss_req_t'(i_i_info);

  // dcache wins a tie unless it also won the previous grant
  assign w_pick_d      = w_d_pend && (!w_i_pend || (r_last != CACHE_ID_DCACHE));
  assign o_grant_c     = i_grant_en && (w_d_pend || w_i_pend);
  assign o_grant_id_c  = w_pick_d ? CACHE_ID_DCACHE : CACHE_ID_ICACHE;
  assign o_grant_req_c = w_pick_d ? w_d_cur : w_i_cur;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_d_flag <= 1'b0;
      r_i_flag <= 1'b0;
      r_last   <= 1'b0;
      r_d_req  <= '0;
      r_i_req  <= '0;
    end else begin
      if (i_d_valid && !r_d_flag) begin
        r_d_req  <= miss_req_t'(i_d_info);
        r_d_flag <= 1'b1;
      end else if (i_clr && (i_clr_id == CACHE_ID_DCACHE)) begin
        r_d_flag <= 1'b0;
      end
      if (i_i_valid && !r_i_flag) begin
        r_i_req  <= miss_req_t'(i_i_info);
        r_i_flag <= 1'b1;
      end else if (i_clr && (i_clr_id == CACHE_ID_ICACHE)) begin
        r_i_flag <= 1'b0;
      end
      if (o_grant_c) begin
        r_last <= o_grant_id_c;
      end
    end
  end

endmodule

// File: rtl/wb_miss_master.sv
// Wishbone classic initiator: turns each cache line miss into one locked
// four-beat cycle and returns the line (or a bus error) to the requesting cache.
module wb_miss_master
  import core_pkg::*;
#(
  parameter logic [31:0] WB_BASE   = 32'h3000_0000,
  parameter int unsigned MEM_LINES = 320,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   dcache_req_valid_miss,
  input  logic [MISS_INFO_W-1:0] dcache_req_info_miss,
  input  logic                   icache_req_valid_miss,
  input  logic [MISS_INFO_W-1:0] icache_req_info_miss,
  output logic                   rsp_valid_miss,
  output logic [LINE_W-1:0]      rsp_data_miss,
  output logic                   rsp_cache_id,
  output logic                   rsp_bus_error,
  output logic                   wbm_cyc_o,
  output logic                   wbm_stb_o,
  output logic                   wbm_we_o,
  output logic [3:0]             wbm_sel_o,
  output logic [31:0]            wbm_adr_o,
  output logic [WORD_W-1:0]      wbm_dat_o,
  input  logic [WORD_W-1:0]      wbm_dat_i,
  input  logic                   wbm_ack_i,
  input  logic                   wbm_err_i
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_BEAT     = 3'd1;
  localparam logic [2:0] ST_GAP      = 3'd2;
  localparam logic [2:0] ST_RESP_ERR = 3'd3;
  localparam logic [2:0] ST_RESP     = 3'd4;

  function automatic logic [31:0] beat_adr(input logic [LINE_ADDR_W-1:0] line,
                                           input logic [BEAT_W-1:0] k);
    return WB_BASE + 32'({line, 4'b0000}) + 32'({k, 2'b00});
  endfunction

  logic [2:0]        r_state,     w_state_d;
  logic [BEAT_W-1:0] r_beat,      w_beat_d;
  logic [TMO_W-1:0]  r_tmo,       w_tmo_d;
  logic [LINE_W-1:0] r_line,      w_line_d;
  miss_req_t         r_req,       w_req_d;
  logic              r_id,        w_id_d;
  logic              r_cyc,       w_cyc_d;
  logic              r_stb,       w_stb_d;
  logic              r_we,        w_we_d;
  logic [3:0]        r_sel,       w_sel_d;
  logic [31:0]       r_adr,       w_adr_d;
  logic [WORD_W-1:0] r_dat,       w_dat_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [LINE_W-1:0] r_rsp_data,  w_rsp_data_d;
  logic              r_rsp_id,    w_rsp_id_d;
  logic              r_rsp_err,   w_rsp_err_d;
  logic              w_launch;
  logic              w_bus_idle;

  logic      w_grant;
  logic      w_grant_id;
  miss_req_t w_grant_req;

  miss_req_arbiter u_arb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .i_d_valid     (dcache_req_valid_miss),
    .i_d_info      (dcache_req_info_miss),
    .i_i_valid     (icache_req_valid_miss),
    .i_i_info      (icache_req_info_miss),
    .i_grant_en    (r_state == ST_IDLE),
    .i_clr         (r_state == ST_RESP),
    .i_clr_id      (r_id),
    .o_grant_c     (w_grant),
    .o_grant_id_c  (w_grant_id),
    .o_grant_req_c (w_grant_req)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_d     = r_state;
    w_beat_d      = r_beat;
    w_tmo_d       = r_tmo;
    w_line_d      = r_line;
    w_req_d       = r_req;
    w_id_d        = r_id;
    w_cyc_d       = r_cyc;
    w_stb_d       = r_stb;
    w_we_d        = r_we;
    w_sel_d       = r_sel;
    w_adr_d       = r_adr;
    w_dat_d       = r_dat;
    w_rsp_valid_d = 1'b0;
    w_rsp_data_d  = '0;
    w_rsp_id_d    = 1'b0;
    w_rsp_err_d   = 1'b0;
    w_launch      = 1'b0;
    w_bus_idle    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_req_d  = w_grant_req;
          w_id_d   = w_grant_id;
          w_beat_d = '0;
          w_tmo_d  = '0;
          w_line_d = '0;
          if (32'(w_grant_req.line_addr) >= 32'(MEM_LINES)) begin
            w_state_d = ST_RESP_ERR;
          end else begin
            w_state_d = ST_BEAT;
            w_launch  = 1'b1;
          end
        end
      end
      ST_BEAT: begin
        // err outranks ack; a silent slave is treated as an error
        if (wbm_err_i || (!wbm_ack_i && (r_tmo == TMO_W'(TIMEOUT - 1)))) begin
          w_state_d     = ST_RESP;
          w_bus_idle    = 1'b1;
          w_rsp_valid_d = 1'b1;
          w_rsp_id_d    = r_id;
          w_rsp_err_d   = 1'b1;
        end else if (wbm_ack_i) begin
          if (!r_req.write) begin
            w_line_d[{r_beat, 5'b00000} +: WORD_W] = wbm_dat_i;
          end
          w_tmo_d = '0;
          if (r_beat == BEAT_W'(BEATS - 1)) begin
            w_state_d     = ST_RESP;
            w_bus_idle    = 1'b1;
            w_rsp_valid_d = 1'b1;
            w_rsp_id_d    = r_id;
            w_rsp_data_d  = r_req.write ? '0 : w_line_d;
          end else begin
            w_state_d = ST_GAP;
            w_beat_d  = r_beat + BEAT_W'(1);
            w_stb_d   = 1'b0;
            w_sel_d   = 4'h0;
          end
        end else begin
          w_tmo_d = r_tmo + TMO_W'(1);
        end
      end
      ST_GAP: begin
        w_state_d = ST_BEAT;
        w_launch  = 1'b1;
      end
      ST_RESP_ERR: begin
        w_state_d     = ST_RESP;
        w_rsp_valid_d = 1'b1;
        w_rsp_id_d    = r_id;
        w_rsp_err_d   = 1'b1;
      end
      ST_RESP: begin
        w_state_d = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase

    // Present beat w_beat_d of the current request on the bus
    if (w_launch) begin
      w_cyc_d = 1'b1;
      w_stb_d = 1'b1;
      w_sel_d = 4'hF;
      w_we_d  = w_req_d.write;
      w_adr_d = beat_adr(w_req_d.line_addr, w_beat_d);
      w_dat_d = w_req_d.write ? w_req_d.data[{w_beat_d, 5'b00000} +: WORD_W] : '0;
    end
    if (w_bus_idle) begin
      w_cyc_d = 1'b0;
      w_stb_d = 1'b0;
      w_we_d  = 1'b0;
      w_sel_d = 4'h0;
      w_adr_d = '0;
      w_dat_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_line      <= '0;
      r_req       <= '0;
      r_id        <= 1'b0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= 4'h0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_beat      <= w_beat_d;
      r_tmo       <= w_tmo_d;
      r_line      <= w_line_d;
      r_req       <= w_req_d;
      r_id        <= w_id_d;
      r_cyc       <= w_cyc_d;
      r_stb       <= w_stb_d;
      r_we        <= w_we_d;
      r_sel       <= w_sel_d;
      r_adr       <= w_adr_d;
      r_dat       <= w_dat_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_id    <= w_rsp_id_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

  assign rsp_valid_miss = r_rsp_valid;
  assign rsp_data_miss  = r_rsp_data;
  assign rsp_cache_id   = r_rsp_id;
  assign rsp_bus_error  = r_rsp_err;
  assign wbm_cyc_o      = r_cyc;
  assign wbm_stb_o      = r_stb;
  assign wbm_we_o       = r_we;
  assign wbm_sel_o      = r_sel;
  assign wbm_adr_o      = r_adr;
  assign wbm_dat_o      = r_dat;

endmodule

// File: tb/tb_wb_miss_master.sv
// Directed bench for wb_miss_master with a small configurable Wishbone slave.
module tb_wb_miss_master;
  import core_pkg::*;

  localparam logic [127:0] RD_LINE = 128'h00000044_00000033_00000022_00000011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i = 1'b1;
  logic         d_valid = 1'b0, i_valid = 1'b0;
  logic [148:0] d_info = '0, i_info = '0;
  logic         rsp_valid_miss, rsp_cache_id, rsp_bus_error;
  logic [127:0] rsp_data_miss;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i, wbm_err_i;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i;

  int vectors = 0;
  int miscompares = 0;

  wb_miss_master dut (
    .clk_i(clk), .reset_i(reset_i),
    .dcache_req_valid_miss(d_valid), .dcache_req_info_miss(d_info),
    .icache_req_valid_miss(i_valid), .icache_req_info_miss(i_info),
    .rsp_valid_miss(rsp_valid_miss), .rsp_data_miss(rsp_data_miss),
    .rsp_cache_id(rsp_cache_id), .rsp_bus_error(rsp_bus_error),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i)
  );

  // Slave: responds after wait_states cycles of stb; can error a chosen beat or never respond
  int unsigned wait_states = 0;
  int unsigned w_cnt = 0;
  bit          never_ack = 1'b0;
  bit          err_en = 1'b0;
  logic [1:0]  err_beat = 2'd0;
  logic [31:0] rd_words [4];
  logic [1:0]  s_k;
  logic        s_ready;

  assign s_k       = wbm_adr_o[3:2];
  assign s_ready   = wbm_cyc_o && wbm_stb_o && (w_cnt >= wait_states);
  assign wbm_ack_i = s_ready && !never_ack;
  assign wbm_err_i = s_ready && err_en && (s_k == err_beat);
  assign wbm_dat_i = rd_words[s_k];

  always @(posedge clk)
    w_cnt <= (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) ? w_cnt + 1 : 0;

  // Bus monitor, sampled mid-cycle
  logic [31:0] log_adr [$];
  logic [31:0] log_dat [$];
  logic        log_we  [$];
  int unsigned stb_cycles = 0, cyc_cycles = 0, k3_stb = 0;

  always @(posedge clk) begin
    #2;
    if (wbm_cyc_o) cyc_cycles++;
    if (wbm_cyc_o && wbm_stb_o) begin
      stb_cycles++;
      if (s_k == 2'd3) k3_stb++;
      if (wbm_ack_i && !wbm_err_i) begin
        log_adr.push_back(wbm_adr_o);
        log_dat.push_back(wbm_dat_o);
        log_we.push_back(wbm_we_o);
      end
    end
  end

  function automatic logic [148:0] mk(input logic [19:0] line, input logic wr, input logic [127:0] d);
    return {line, wr, d};
  endfunction

  task automatic send(input bit to_d, input logic [148:0] dinf, input bit to_i, input logic [148:0] iinf);
    @(negedge clk);
    d_valid = to_d; d_info = dinf;
    i_valid = to_i; i_info = iinf;
    @(negedge clk);
    d_valid = 1'b0; i_valid = 1'b0;
  endtask

  // cyc = cycle index of the response counting the capture cycle as 0
  task automatic wait_rsp(output bit got, output int cyc, output logic id, output logic err,
                          output logic [127:0] data);
    got = 1'b0; cyc = 1; id = 1'b0; err = 1'b0; data = '0;
    while (!got && cyc < 600) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_miss) begin
        got = 1'b1; id = rsp_cache_id; err = rsp_bus_error; data = rsp_data_miss;
      end
    end
  endtask

  task automatic slave_cfg(input int unsigned ws, input bit ena_err, input logic [1:0] eb, input bit never);
    wait_states = ws; err_en = ena_err; err_beat = eb; never_ack = never;
    rd_words[0] = 32'h11; rd_words[1] = 32'h22; rd_words[2] = 32'h33; rd_words[3] = 32'h44;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
         rsp_valid_miss, rsp_cache_id, rsp_bus_error, rsp_data_miss} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: cyc=%b stb=%b adr=%h rsp_valid=%b, required all zero",
               wbm_cyc_o, wbm_stb_o, wbm_adr_o, rsp_valid_miss);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_read();
    bit got; int cyc; logic id, err; logic [127:0] data;
    int base = log_adr.size();
    slave_cfg(0, 0, 2'd0, 0);
    send(1'b1, mk(20'd5, 1'b0, '0), 1'b0, '0);
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if ({got, id, err, data} !== {1'b1, 1'b1, 1'b0, RD_LINE}) begin
      miscompares++;
      $display("FAIL read_rsp: got=%b id=%b err=%b data=%h, required 1 1 0 %h", got, id, err, data, RD_LINE);
    end
    vectors++;
    if (cyc !== 8) begin
      miscompares++;
      $display("FAIL read_latency: %0d cycles, required 8", cyc);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (base + k >= log_adr.size() ||
          {log_adr[base+k], log_we[base+k]} !== {32'h3000_0050 + 32'(4*k), 1'b0}) begin
        miscompares++;
        $display("FAIL read_beat%0d: log entries=%0d, required adr %h we=0", k,
                 log_adr.size() - base, 32'h3000_0050 + 32'(4*k));
      end
    end
  endtask

  task automatic test_write();
    bit got; int cyc; logic id, err; logic [127:0] data;
    int base = log_adr.size();
    slave_cfg(2, 0, 2'd0, 0);
    send(1'b0, '0, 1'b1, mk(20'd2, 1'b1, {32'hD, 32'hC, 32'hB, 32'hA}));
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if ({got, id, err, data} !== {1'b1, 1'b0, 1'b0, 128'h0}) begin
      miscompares++;
      $display("FAIL write_rsp: got=%b id=%b err=%b data=%h, required 1 0 0 0", got, id, err, data);
    end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (base + k >= log_adr.size() ||
          {log_adr[base+k], log_we[base+k], log_dat[base+k]} !==
          {32'h3000_0020 + 32'(4*k), 1'b1, 32'hA + 32'(k)}) begin
        miscompares++;
        $display("FAIL write_beat%0d: log entries=%0d, required adr %h we=1 dat %h", k,
                 log_adr.size() - base, 32'h3000_0020 + 32'(4*k), 32'hA + 32'(k));
      end
    end
  endtask

  task automatic test_arbitration();
    bit got; int cyc; logic id, err; logic [127:0] data;
    logic exp_id [5];
    exp_id[0] = 1'b1; exp_id[1] = 1'b0; exp_id[2] = 1'b1; exp_id[3] = 1'b0; exp_id[4] = 1'b1;
    slave_cfg(0, 0, 2'd0, 0);
    for (int r = 0; r < 5; r++) begin
      if (r == 0 || r == 3) send(1'b1, mk(20'd1, 1'b0, '0), 1'b1, mk(20'd3, 1'b0, '0));
      else if (r == 2)      send(1'b1, mk(20'd4, 1'b0, '0), 1'b0, '0);
      wait_rsp(got, cyc, id, err, data);
      vectors++;
      if ({got, id} !== {1'b1, exp_id[r]}) begin
        miscompares++;
        $display("FAIL arb_order%0d: got=%b id=%b, required 1 %b", r, got, id, exp_id[r]);
      end
    end
  endtask

  task automatic test_bad_addr();
    bit got; int cyc; logic id, err; logic [127:0] data;
    int unsigned cyc0 = cyc_cycles;
    int base;
    slave_cfg(0, 0, 2'd0, 0);
    send(1'b1, mk(20'd320, 1'b0, '0), 1'b0, '0);
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if ({got, id, err, data, cyc_cycles - cyc0, 32'(cyc)} !==
        {1'b1, 1'b1, 1'b1, 128'h0, 32'd0, 32'd2}) begin
      miscompares++;
      $display("FAIL bad_addr: got=%b id=%b err=%b cyc_cycles=%0d at=%0d, required 1 1 1 0 2",
               got, id, err, cyc_cycles - cyc0, cyc);
    end
    base = log_adr.size();
    send(1'b0, '0, 1'b1, mk(20'd319, 1'b0, '0));
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if (base >= log_adr.size() || {got, err, log_adr[base]} !== {1'b1, 1'b0, 32'h3000_13F0}) begin
      miscompares++;
      $display("FAIL last_line: got=%b err=%b entries=%0d, required ok at 300013f0",
               got, err, log_adr.size() - base);
    end
  endtask

  task automatic test_bus_err();
    bit got; int cyc; logic id, err; logic [127:0] data;
    int base = log_adr.size();
    int unsigned k3 = k3_stb;
    slave_cfg(1, 1, 2'd2, 0);
    send(1'b1, mk(20'd6, 1'b0, '0), 1'b0, '0);
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if ({got, id, err, data, wbm_cyc_o, 32'(cyc)} !== {1'b1, 1'b1, 1'b1, 128'h0, 1'b0, 32'd9}) begin
      miscompares++;
      $display("FAIL bus_err_rsp: got=%b id=%b err=%b data=%h cyc_o=%b at=%0d, required 1 1 1 0 0 9",
               got, id, err, data, wbm_cyc_o, cyc);
    end
    vectors++;
    if ({32'(log_adr.size() - base), k3_stb - k3} !== {32'd2, 32'd0}) begin
      miscompares++;
      $display("FAIL bus_err_beats: acked=%0d beat3_stb=%0d, required 2 0",
               log_adr.size() - base, k3_stb - k3);
    end
    slave_cfg(0, 0, 2'd0, 0);
  endtask

  task automatic test_timeout();
    bit got; int cyc; logic id, err; logic [127:0] data;
    int unsigned s0 = stb_cycles;
    slave_cfg(0, 0, 2'd0, 1);
    send(1'b0, '0, 1'b1, mk(20'd8, 1'b0, '0));
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if ({got, id, err, data, stb_cycles - s0, 32'(cyc)} !==
        {1'b1, 1'b0, 1'b1, 128'h0, 32'd255, 32'd256}) begin
      miscompares++;
      $display("FAIL timeout: got=%b id=%b err=%b stb_cycles=%0d at=%0d, required 1 0 1 255 256",
               got, id, err, stb_cycles - s0, cyc);
    end
    slave_cfg(0, 0, 2'd0, 0);
  endtask

  task automatic test_reset_mid();
    bit got; int cyc; logic id, err; logic [127:0] data;
    int seen = 0;
    slave_cfg(3, 0, 2'd0, 0);
    send(1'b1, mk(20'd9, 1'b0, '0), 1'b0, '0);
    for (int n = 0; n < 100 && !(wbm_stb_o && s_k == 2'd1); n++) @(negedge clk);
    vectors++;
    if (!(wbm_stb_o && s_k == 2'd1)) begin
      miscompares++;
      $display("FAIL reach_beat1: stb=%b adr=%h, required stb on beat 1", wbm_stb_o, wbm_adr_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    vectors++;
    if ({wbm_cyc_o, wbm_stb_o, rsp_valid_miss} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_bus: cyc=%b stb=%b rsp=%b, required 000", wbm_cyc_o, wbm_stb_o, rsp_valid_miss);
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (rsp_valid_miss || wbm_cyc_o) seen++;
    end
    vectors++;
    if (seen !== 0) begin
      miscompares++;
      $display("FAIL reset_mid_quiet: %0d active cycles after reset, required 0", seen);
    end
    slave_cfg(0, 0, 2'd0, 0);
    send(1'b1, mk(20'd10, 1'b0, '0), 1'b0, '0);
    wait_rsp(got, cyc, id, err, data);
    vectors++;
    if ({got, id, err, data, 32'(cyc)} !== {1'b1, 1'b1, 1'b0, RD_LINE, 32'd8}) begin
      miscompares++;
      $display("FAIL reset_mid_fresh: got=%b id=%b err=%b data=%h at=%0d, required 1 1 0 %h 8",
               got, id, err, data, cyc, RD_LINE);
    end
  endtask

  initial begin
    slave_cfg(0, 0, 2'd0, 0);
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_bad_addr();
    test_bus_err();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
